// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with an iterative unsigned multiplier/divider.
//
// Single-cycle ops (logic, ADD/SUB, SLT/SLTU) and illegal codes complete one cycle
// after accept. MUL/MULHU/DIVU/REMU iterate one bit per cycle for WIDTH cycles.
// The unit holds one op at a time and uses valid/ready on both sides.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   op1/op2/f valid          in_ready   unit can accept a new op
//   op1, op2   operands                 f          function code
//   out_valid  result/flags valid       out_ready  consumer takes result
//   result     registered result        zero       result == 0
//   ovf        signed overflow (ADD/SUB only)
//   illegal    undefined function code; result forced to 0
module alu_multicycle #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // Shared iteration register: {partial product hi, multiplier/product lo} for
    // multiply, {partial remainder, dividend/quotient} for divide.
    logic [2*WIDTH-1:0]   p_q, p_d;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 div_q, div_d;
    logic                 hi_q, hi_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 illegal_q, illegal_d;

    logic [WIDTH-1:0]     add_sum, sub_diff, sc_res;
    logic                 sc_ovf, sc_ill, multi;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, iter_next;

    assign add_sum  = op1 + op2;
    assign sub_diff = op1 - op2;

    // Single-cycle datapath and decode.
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        multi  = 1'b0;
        case (f)
            4'b0000: sc_res = op1 & op2;
            4'b0001: sc_res = op1 | op2;
            4'b0010: begin
                sc_res = add_sum;
                sc_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            4'b0100: sc_res = op1 & ~op2;
            4'b0101: sc_res = op1 | ~op2;
            4'b0110: begin
                sc_res = sub_diff;
                sc_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_diff[WIDTH-1] != op1[WIDTH-1]);
            end
            4'b0111: sc_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            4'b1000: sc_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            4'b1001, 4'b1010, 4'b1011, 4'b1100: begin
                if (MULDIV) multi  = 1'b1;
                else        sc_ill = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // One shift-add multiply step: add multiplicand if lsb set, shift right.
    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, p_q[WIDTH-1:1]};

    // One restoring-divide step. Divide by zero falls out naturally: every step
    // subtracts 0, so the quotient fills with ones and the remainder becomes op1.
    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        p_q[WIDTH-2:0], div_ge};

    assign iter_next = div_q ? div_next : mul_next;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        hi_d      = hi_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (multi) begin
                        state_d = StBusy;
                        cnt_d   = '0;
                        div_d   = (f == 4'b1011) || (f == 4'b1100);
                        hi_d    = (f == 4'b1010) || (f == 4'b1100);
                        opnd_d  = div_d ? op2 : op1;
                        p_d     = {{WIDTH{1'b0}}, (div_d ? op1 : op2)};
                    end else begin
                        state_d   = StDone;
                        result_d  = sc_res;
                        zero_d    = (sc_res == '0);
                        ovf_d     = sc_ovf;
                        illegal_d = sc_ill;
                    end
                end
            end
            StBusy: begin
                p_d   = iter_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d   = StDone;
                    result_d  = hi_q ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];
                    zero_d    = (result_d == '0);
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            p_q       <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            hi_q      <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            hi_q      <= hi_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    // Gated with reset_n so the unit never advertises ready while held in reset.
    assign in_ready  = reset_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op1, op2, result;
    logic [3:0]  f;
    logic        zero, ovf, illegal;

    logic       w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready;
    logic [7:0] w8_op1, w8_op2, w8_result;
    logic [3:0] w8_f;
    logic       w8_zero, w8_ovf, w8_illegal;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32), .MULDIV(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .f(f), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf), .illegal(illegal)
    );

    alu_multicycle #(.WIDTH(8), .MULDIV(1'b1)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .op1(w8_op1), .op2(w8_op2), .f(w8_f), .out_valid(w8_out_valid),
        .out_ready(w8_out_ready), .result(w8_result), .zero(w8_zero), .ovf(w8_ovf),
        .illegal(w8_illegal)
    );

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the function table, using wide arithmetic.
    function automatic void model(input logic [3:0] fc, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic o, output logic il, output int lat);
        longint unsigned prod;
        longint          sa, sb, s;
        prod = longint'(a) * longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        r = 32'h0; o = 1'b0; il = 1'b0; lat = 1;
        case (fc)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = sa + sb; r = a + b; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd4:  r = a & ~b;
            4'd5:  r = a | ~b;
            4'd6:  begin s = sa - sb; r = a - b; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  begin r = prod[31:0];  lat = 33; end
            4'd10: begin r = prod[63:32]; lat = 33; end
            4'd11: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
            4'd12: begin r = (b == 0) ? a : a % b; lat = 33; end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] fc, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic o,
                          output logic il, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin tick(); guard++; end
        f = fc; op1 = a; op2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        r = result; z = zero; o = ovf; il = illegal;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] r, er, a, b;
        logic        z, o, il, eo, eil, bad_ready;
        int          lat, elat, c;
        logic [3:0]  fc;

        vecs = '{
            '{4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1'b0, 1},
            '{4'b0110, 32'h5,         32'h5,         32'h0,         1'b0, 1'b0, 1},
            '{4'b1000, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1},
            '{4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 1},
            '{4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33},
            '{4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 33},
            '{4'b1011, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33},
            '{4'b1100, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33},
            '{4'b1011, 32'd12345,     32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 33},
            '{4'b1100, 32'd9,         32'd0,         32'd9,         1'b0, 1'b0, 33},
            '{4'b0011, 32'h1234,      32'h5678,      32'h0,         1'b0, 1'b1, 1},
            '{4'b1101, 32'hFFFF,      32'h1,         32'h0,         1'b0, 1'b1, 1},
            '{4'b1111, 32'h1,         32'h1,         32'h0,         1'b0, 1'b1, 1},
            '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1},
            '{4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1},
            '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0, 1'b0, 1'b0, 1},
            '{4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0FF_F0FF, 1'b0, 1'b0, 1},
            '{4'b0110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b0, 1},
            '{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 1}
        };

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; f = '0;
        w8_in_valid = 1'b0; w8_out_ready = 1'b0; w8_op1 = '0; w8_op2 = '0; w8_f = '0;
        repeat (3) tick();
        check("reset out_valid", out_valid, 0);
        check("reset zero", zero, 1);
        check("reset result", result, 0);
        check("reset ovf", ovf, 0);
        check("reset illegal", illegal, 0);
        check("reset in_ready low in reset", in_ready, 0);
        reset_n = 1'b1;
        tick();
        check("in_ready after reset", in_ready, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, z, o, il, lat);
            check($sformatf("vec%0d result", i), r, vecs[i].res);
            check($sformatf("vec%0d zero", i), z, (vecs[i].res == 0));
            check($sformatf("vec%0d ovf", i), o, vecs[i].ovf);
            check($sformatf("vec%0d illegal", i), il, vecs[i].ill);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
        end

        for (int i = 0; i < 150; i++) begin
            fc = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = $urandom();
            c  = $urandom_range(0, 7);
            if (c == 0) b = 32'h0;
            else if (c == 1) a = 32'h7FFF_FFFF;
            else if (c == 2) b = 32'($urandom_range(1, 20));
            model(fc, a, b, er, eo, eil, elat);
            run_op(fc, a, b, r, z, o, il, lat);
            check($sformatf("rnd%0d f=%0d result", i, fc), r, er);
            check($sformatf("rnd%0d zero", i), z, (er == 0));
            check($sformatf("rnd%0d ovf", i), o, eo);
            check($sformatf("rnd%0d illegal", i), il, eil);
            check($sformatf("rnd%0d latency", i), lat, elat);
        end

        // Inputs wiggle during BUSY and must be ignored; in_ready stays low.
        f = 4'b1011; op1 = 32'd1000; op2 = 32'd10; in_valid = 1'b1;
        tick();
        lat = 1; bad_ready = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) bad_ready = 1'b1;
            op1 = $urandom(); op2 = $urandom(); f = 4'($urandom_range(0, 15));
            tick(); lat++;
        end
        in_valid = 1'b0;
        check("busy in_ready low", bad_ready, 0);
        check("busy ignore result", result, 32'd100);
        check("busy ignore latency", lat, 33);

        // Output held while the consumer stalls.
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold out_valid", out_valid, 1);
            check("hold result", result, 32'd100);
            check("hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release out_valid", out_valid, 0);
        check("release in_ready", in_ready, 1);

        // Reset in the middle of a divide.
        f = 4'b1011; op1 = 32'd999; op2 = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        check("midreset out_valid", out_valid, 0);
        check("midreset zero", zero, 1);
        check("midreset result", result, 0);
        reset_n = 1'b1;
        tick();
        check("midreset in_ready", in_ready, 1);
        run_op(4'b0010, 32'd2, 32'd3, r, z, o, il, lat);
        check("post-reset ADD result", r, 32'd5);
        check("post-reset ADD latency", lat, 1);
        run_op(4'b0011, 32'd2, 32'd3, r, z, o, il, lat);
        check("post-reset illegal flag", il, 1);
        check("post-reset illegal result", r, 0);

        // Narrow instance.
        w8_f = 4'b1010; w8_op1 = 8'hFF; w8_op2 = 8'hFF; w8_in_valid = 1'b1;
        tick();
        w8_in_valid = 1'b0;
        lat = 1;
        while (!w8_out_valid && lat < 100) begin tick(); lat++; end
        check("w8 MULHU result", w8_result, 8'hFE);
        check("w8 MULHU latency", lat, 9);
        w8_out_ready = 1'b1;
        tick();
        w8_out_ready = 1'b0;
        check("w8 release in_ready", w8_in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
